// File: rtl/uart_tx_framer.sv
// UART transmit framer: takes bytes over valid/ready and emits start, 8 data bits
// LSB-first, optional parity and 1-2 stop bits, pacing each bit from an external flex counter.
module uart_tx_framer #(
  parameter int COUNTSIZE    = 1024,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  localparam int COUNTWIDTH  = $clog2(COUNTSIZE)
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  enableCounter,
  output logic [COUNTWIDTH-1:0] maxCount,
  input  logic                  strobe
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_ODD   = 1'(PARITY_ODD);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        stop_q, stop_d;
  logic        par_q, par_d;
  logic        tx_out_q, tx_out_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        en_q, en_d;

  assign maxCount      = COUNTWIDTH'(CLKS_PER_BIT - 1);
  assign tx_out        = tx_out_q;
  assign tx_ready      = ready_q;
  assign busy          = busy_q;
  assign enableCounter = en_q;

  // Outputs are computed for the state being entered so they appear registered
  // in the same cycle the state register changes.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    par_d    = par_q;
    tx_out_d = tx_out_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    en_d     = en_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d  = tx_data;
          par_d    = (^tx_data) ^ PAR_ODD;
          state_d  = START;
          tx_out_d = 1'b0;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end
      START: begin
        if (strobe) begin
          state_d  = DATA;
          idx_d    = '0;
          tx_out_d = shift_q[0];
        end
      end
      DATA: begin
        if (strobe) begin
          if (idx_q == 3'd7) begin
            stop_d = 1'b0;
            if (PARITY_EN != 0) begin
              state_d  = PARITY;
              tx_out_d = par_q;
            end else begin
              state_d  = STOP;
              tx_out_d = 1'b1;
            end
          end else begin
            shift_d  = shift_q >> 1;
            idx_d    = idx_q + 3'd1;
            tx_out_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (strobe) begin
          state_d  = STOP;
          stop_d   = 1'b0;
          tx_out_d = 1'b1;
        end
      end
      STOP: begin
        if (strobe) begin
          if (stop_q == LAST_STOP) begin
            state_d  = IDLE;
            tx_out_d = 1'b1;
            en_d     = 1'b0;
            busy_d   = 1'b0;
            ready_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
        en_d     = 1'b0;
        busy_d   = 1'b0;
        ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      par_q    <= 1'b0;
      tx_out_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      par_q    <= par_d;
      tx_out_q <= tx_out_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four framer configurations, each paced by
// its own flex counter model, checked cycle by cycle against hand-built bit frames.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] tx_data;
  logic [3:0] vld;
  logic [3:0] inj;
  logic [3:0] stb;
  logic       tx_out_w [4];
  logic       ready_w  [4];
  logic       busy_w   [4];
  logic       en_w     [4];
  logic [9:0] maxc_w   [4];
  logic [9:0] cnt      [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .RST(RST), .tx_data(tx_data), .tx_valid(vld[0]), .tx_ready(ready_w[0]),
    .tx_out(tx_out_w[0]), .busy(busy_w[0]), .enableCounter(en_w[0]), .maxCount(maxc_w[0]),
    .strobe(stb[0]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .RST(RST), .tx_data(tx_data), .tx_valid(vld[1]), .tx_ready(ready_w[1]),
    .tx_out(tx_out_w[1]), .busy(busy_w[1]), .enableCounter(en_w[1]), .maxCount(maxc_w[1]),
    .strobe(stb[1]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .RST(RST), .tx_data(tx_data), .tx_valid(vld[2]), .tx_ready(ready_w[2]),
    .tx_out(tx_out_w[2]), .busy(busy_w[2]), .enableCounter(en_w[2]), .maxCount(maxc_w[2]),
    .strobe(stb[2]));
  uart_tx_framer #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .RST(RST), .tx_data(tx_data), .tx_valid(vld[3]), .tx_ready(ready_w[3]),
    .tx_out(tx_out_w[3]), .busy(busy_w[3]), .enableCounter(en_w[3]), .maxCount(maxc_w[3]),
    .strobe(stb[3]));

  // Flex counter stand-in: holds 0 while disabled, strobes at maxCount then wraps.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (RST || !en_w[i])            cnt[i] <= '0;
      else if (cnt[i] == maxc_w[i])   cnt[i] <= '0;
      else                            cnt[i] <= cnt[i] + 10'd1;
    end
  end

  always_comb begin
    stb = '0;
    for (int i = 0; i < 4; i++)
      stb[i] = (en_w[i] && (cnt[i] == maxc_w[i])) || inj[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("%s u%0d tx_out", tag, k), 32'(tx_out_w[k]), 32'd1);
    chk($sformatf("%s u%0d tx_ready", tag, k), 32'(ready_w[k]), 32'd1);
    chk($sformatf("%s u%0d busy", tag, k), 32'(busy_w[k]), 32'd0);
    chk($sformatf("%s u%0d enableCounter", tag, k), 32'(en_w[k]), 32'd0);
  endtask

  // Called in the first START cycle; returns in the first IDLE cycle after the frame.
  task automatic check_frame(input int k, input logic [7:0] b, input bit pe, input bit po,
                             input int sb);
    logic bits [12];
    int   n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    n = 9;
    if (pe) begin
      bits[9] = (^b) ^ po;
      n = 10;
    end
    for (int s = 0; s < sb; s++) bits[n+s] = 1'b1;
    n = n + sb;
    chk($sformatf("u%0d b%0h start tx_ready", k, b), 32'(ready_w[k]), 32'd0);
    chk($sformatf("u%0d b%0h start enableCounter", k, b), 32'(en_w[k]), 32'd1);
    for (int cyc = 0; cyc < n * 4; cyc++) begin
      chk($sformatf("u%0d b%0h tx_out cyc%0d", k, b, cyc), 32'(tx_out_w[k]), 32'(bits[cyc/4]));
      chk($sformatf("u%0d b%0h busy cyc%0d", k, b, cyc), 32'(busy_w[k]), 32'd1);
      tick();
    end
    chk_idle(k, $sformatf("end b%0h", b));
  endtask

  task automatic send(input int k, input logic [7:0] b);
    tx_data = b;
    vld[k]  = 1'b1;
    tick();
    vld[k]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    vld = '1;
    inj = '0;
    tx_data = 8'hA5;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      chk_idle(k, "reset");
      chk($sformatf("reset u%0d maxCount", k), 32'(maxc_w[k]), 32'd3);
    end
    vld = '0;
    RST = 1'b0;
    tick();

    // Plain frame, then even/odd parity variants.
    send(0, 8'hA5); check_frame(0, 8'hA5, 1'b0, 1'b0, 1);
    tick();
    send(1, 8'hA5); check_frame(1, 8'hA5, 1'b1, 1'b0, 1);
    tick();
    send(2, 8'hA5); check_frame(2, 8'hA5, 1'b1, 1'b1, 1);
    tick();
    send(1, 8'h07); check_frame(1, 8'h07, 1'b1, 1'b0, 1);
    tick();

    // Back-to-back with tx_valid held; tx_data moves mid-frame.
    tx_data = 8'h00;
    vld[0]  = 1'b1;
    tick();
    tx_data = 8'hFF;
    check_frame(0, 8'h00, 1'b0, 1'b0, 1);
    tick();
    vld[0]  = 1'b0;
    tx_data = 8'h12;
    check_frame(0, 8'hFF, 1'b0, 1'b0, 1);
    tick();

    // Reset during data bit 3 of 0x3C, then a clean frame.
    send(0, 8'h3C);
    repeat (17) tick();
    chk("midframe bit3 tx_out", 32'(tx_out_w[0]), 32'd1);
    chk("midframe enableCounter", 32'(en_w[0]), 32'd1);
    RST = 1'b1;
    tick();
    chk_idle(0, "after reset");
    RST = 1'b0;
    tick();
    send(0, 8'h3C); check_frame(0, 8'h3C, 1'b0, 1'b0, 1);
    tick();

    // Two stop bits, then a spurious strobe while idle.
    send(3, 8'h55); check_frame(3, 8'h55, 1'b0, 1'b0, 2);
    inj[3] = 1'b1;
    tick();
    inj[3] = 1'b0;
    chk_idle(3, "spurious strobe");
    tick();
    chk_idle(3, "spurious strobe +1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
